// File: rtl/chip8_timer_sched.sv
// CHIP-8 timer scheduler: 60 Hz tick prescaler, CPU/debug load+read arbiter, buzzer register; debug port gated by `CHIP8_TMR_DBG_PORT_EN.
// Accept N -> load/sample N+1 -> rsp_valid N+2; ready held low outside IDLE, so at most one request is in flight.
module chip8_timer_sched #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req_valid,
    input  logic [1:0] cpu_req_op,
    input  logic [7:0] cpu_req_data,
    output logic       cpu_req_ready,
    output logic       cpu_rsp_valid,
    output logic [7:0] cpu_rsp_data,
    input  logic       dbg_req_valid,
    input  logic [1:0] dbg_req_op,
    input  logic [7:0] dbg_req_data,
    output logic       dbg_req_ready,
    output logic       dbg_rsp_valid,
    output logic [7:0] dbg_rsp_data,
    output logic       tmr_tick,
    output logic       tmr_load_delay,
    output logic       tmr_load_sound,
    output logic [7:0] tmr_load_data,
    input  logic [7:0] tmr_delay_val,
    input  logic [7:0] tmr_sound_val,
    output logic       buzzer
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);

    localparam logic [1:0] OP_RD_DT = 2'b00;
    localparam logic [1:0] OP_WR_DT = 2'b01;
    localparam logic [1:0] OP_WR_ST = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_presc;
    logic           r_tick_pend;
    logic [1:0]     r_op;
    logic [7:0]     r_dat;
    logic           r_port_dbg;
    logic [7:0]     r_cpu_rsp;
    logic [7:0]     r_dbg_rsp;
    logic           r_buzzer;
    logic           w_tick_due;
    logic           w_load;
    logic           w_gnt_dbg;
    logic           w_acc_cpu;
    logic           w_acc_dbg;
    logic           w_acc;
    logic [7:0]     w_rsp_val;

`ifdef CHIP8_TMR_DBG_PORT_EN
    logic r_last_dbg;

    // Round-robin: debug wins only if alone or if the CPU was served last.
    assign w_gnt_dbg = dbg_req_valid & (~cpu_req_valid | ~r_last_dbg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_dbg <= 1'b1;
        end else if (w_acc) begin
            r_last_dbg <= w_acc_dbg;
        end
    end
`else
    assign w_gnt_dbg = 1'b0;
`endif

    assign w_acc_cpu  = cpu_req_valid & cpu_req_ready;
    assign w_acc_dbg  = dbg_req_valid & dbg_req_ready;
    assign w_acc      = w_acc_cpu | w_acc_dbg;
    assign w_tick_due = (r_presc == PRESC_LAST);
    assign w_load     = tmr_load_delay | tmr_load_sound;

    // A tick colliding with a load is replayed in the following cycle.
    assign tmr_tick     = (w_tick_due & ~w_load) | r_tick_pend;
    assign cpu_rsp_data = r_cpu_rsp;
    assign dbg_rsp_data = r_dbg_rsp;
    assign buzzer       = r_buzzer;

    always_comb begin
        case (r_op)
            OP_RD_DT: w_rsp_val = tmr_delay_val;
            OP_WR_DT,
            OP_WR_ST: w_rsp_val = r_dat;
            default:  w_rsp_val = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        cpu_req_ready  = 1'b0;
        dbg_req_ready  = 1'b0;
        cpu_rsp_valid  = 1'b0;
        dbg_rsp_valid  = 1'b0;
        tmr_load_delay = 1'b0;
        tmr_load_sound = 1'b0;
        tmr_load_data  = 8'h00;
        case (r_state)
            S_IDLE: begin
                cpu_req_ready = cpu_req_valid & ~w_gnt_dbg;
                dbg_req_ready = w_gnt_dbg;
                if (cpu_req_valid | w_gnt_dbg) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_load_delay = (r_op == OP_WR_DT);
                tmr_load_sound = (r_op == OP_WR_ST);
                if ((r_op == OP_WR_DT) || (r_op == OP_WR_ST)) begin
                    tmr_load_data = r_dat;
                end
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                cpu_rsp_valid = ~r_port_dbg;
                dbg_rsp_valid = r_port_dbg;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc     <= '0;
            r_tick_pend <= 1'b0;
            r_buzzer    <= 1'b0;
        end else begin
            r_presc     <= w_tick_due ? '0 : r_presc + CW'(1);
            r_tick_pend <= w_tick_due & w_load;
            r_buzzer    <= |tmr_sound_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= 2'b00;
            r_dat      <= 8'h00;
            r_port_dbg <= 1'b0;
            r_cpu_rsp  <= 8'h00;
            r_dbg_rsp  <= 8'h00;
        end else begin
            if (w_acc) begin
                r_op       <= w_acc_dbg ? dbg_req_op   : cpu_req_op;
                r_dat      <= w_acc_dbg ? dbg_req_data : cpu_req_data;
                r_port_dbg <= w_acc_dbg;
            end
            if (r_state == S_ISSUE) begin
                if (r_port_dbg) begin
                    r_dbg_rsp <= w_rsp_val;
                end else begin
                    r_cpu_rsp <= w_rsp_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_chip8_timer_sched.sv
// Randomised and directed bench for chip8_timer_sched (DIV=10) against a cycle-timeline reference model.
module tb_chip8_timer_sched;
    localparam int CLK_HZ  = 600;
    localparam int TICK_HZ = 60;
    localparam int DIV     = CLK_HZ / TICK_HZ;

    logic       clk;
    logic       rst;
    logic       cv, dv;
    logic [1:0] cop, dop;
    logic [7:0] cdat, ddat;
    logic       cpu_req_ready, cpu_rsp_valid, dbg_req_ready, dbg_rsp_valid;
    logic [7:0] cpu_rsp_data, dbg_rsp_data;
    logic       tmr_tick, tmr_load_delay, tmr_load_sound, buzzer;
    logic [7:0] tmr_load_data;
    logic [7:0] dly, snd;

    chip8_timer_sched #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .clk(clk), .reset(rst),
        .cpu_req_valid(cv), .cpu_req_op(cop), .cpu_req_data(cdat),
        .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
        .dbg_req_valid(dv), .dbg_req_op(dop), .dbg_req_data(ddat),
        .dbg_req_ready(dbg_req_ready), .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data),
        .tmr_tick(tmr_tick), .tmr_load_delay(tmr_load_delay), .tmr_load_sound(tmr_load_sound),
        .tmr_load_data(tmr_load_data), .tmr_delay_val(dly), .tmr_sound_val(snd), .buzzer(buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: transaction timeline relative to acceptance cycle.
    int         m_cyc;
    bit         m_pend, m_busy, m_port, m_last, m_snd_nz;
    int         m_acc;
    logic [1:0] m_op;
    logic [7:0] m_dat, m_crsp, m_drsp;
    bit         m_cacc, m_dacc;

    logic       h_tick[128], h_ldd[128], h_lds[128], h_crv[128], h_cr[128], h_dr[128], h_buz[128];
    logic [7:0] h_ldat[128], h_crd[128];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, m_cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic       e_tick, e_ldd, e_lds, e_crv, e_drv, e_cr, e_dr, e_buz, due, ld, gnt_dbg;
        logic [7:0] e_ldat;
        int         ph;
        @(negedge clk);
        m_cacc = 1'b0;
        m_dacc = 1'b0;
        if (rst) begin
            m_cyc = 0; m_pend = 0; m_busy = 0; m_last = 1; m_snd_nz = 0;
            m_crsp = 8'h00; m_drsp = 8'h00;
            e_tick = 0; e_ldd = 0; e_lds = 0; e_ldat = 8'h00;
            e_crv = 0; e_drv = 0; e_cr = 0; e_dr = 0; e_buz = 0;
            ld = 0; due = 0; ph = 0;
        end else begin
            ph     = m_busy ? (m_cyc - m_acc) : 0;
            e_ldd  = m_busy && ph == 1 && m_op == 2'd1;
            e_lds  = m_busy && ph == 1 && m_op == 2'd2;
            ld     = e_ldd || e_lds;
            e_ldat = ld ? m_dat : 8'h00;
            due    = (m_cyc % DIV) == DIV - 1;
            e_tick = (due && !ld) || m_pend;
            e_crv  = m_busy && ph == 2 && !m_port;
            e_drv  = m_busy && ph == 2 && m_port;
`ifdef CHIP8_TMR_DBG_PORT_EN
            gnt_dbg = dv && (!cv || !m_last);
`else
            gnt_dbg = 1'b0;
`endif
            e_cr  = !m_busy && cv && !gnt_dbg;
            e_dr  = !m_busy && gnt_dbg;
            e_buz = m_snd_nz;
        end
        chk("tick",    32'(tmr_tick),       32'(e_tick));
        chk("ld_dly",  32'(tmr_load_delay), 32'(e_ldd));
        chk("ld_snd",  32'(tmr_load_sound), 32'(e_lds));
        chk("ld_dat",  32'(tmr_load_data),  32'(e_ldat));
        chk("cpu_rdy", 32'(cpu_req_ready),  32'(e_cr));
        chk("cpu_rv",  32'(cpu_rsp_valid),  32'(e_crv));
        chk("cpu_rd",  32'(cpu_rsp_data),   32'(m_crsp));
        chk("dbg_rdy", 32'(dbg_req_ready),  32'(e_dr));
        chk("dbg_rv",  32'(dbg_rsp_valid),  32'(e_drv));
        chk("dbg_rd",  32'(dbg_rsp_data),   32'(m_drsp));
        chk("buzzer",  32'(buzzer),         32'(e_buz));
        if (!rst) begin
            if (m_cyc < 128) begin
                h_tick[m_cyc] = tmr_tick; h_ldd[m_cyc] = tmr_load_delay; h_lds[m_cyc] = tmr_load_sound;
                h_ldat[m_cyc] = tmr_load_data; h_crv[m_cyc] = cpu_rsp_valid; h_crd[m_cyc] = cpu_rsp_data;
                h_cr[m_cyc] = cpu_req_ready; h_dr[m_cyc] = dbg_req_ready; h_buz[m_cyc] = buzzer;
            end
            if (m_busy && ph == 1) begin
                if (m_port) m_drsp = (m_op == 2'd0) ? dly : (m_op == 2'd3) ? 8'h00 : m_dat;
                else        m_crsp = (m_op == 2'd0) ? dly : (m_op == 2'd3) ? 8'h00 : m_dat;
            end
            m_pend = due && ld;
            if (m_busy && ph == 2) m_busy = 0;
            if (e_cr) begin
                m_busy = 1; m_acc = m_cyc; m_op = cop; m_dat = cdat; m_port = 0; m_last = 0; m_cacc = 1;
            end
            if (e_dr) begin
                m_busy = 1; m_acc = m_cyc; m_op = dop; m_dat = ddat; m_port = 1; m_last = 1; m_dacc = 1;
            end
            m_snd_nz = (snd != 8'h00);
            m_cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; cv = 1'b0; dv = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int cnt, n_acc;
        bit got;
        rst = 1'b1; cv = 0; dv = 0; cop = 0; dop = 0; cdat = 0; ddat = 0; dly = 0; snd = 0;
        m_cyc = 0;
        @(posedge clk);
        #1;

        // Idle after reset: ticks at 9, 19, 29 only.
        reset_dut();
        for (int i = 0; i < 35; i++) step();
        cnt = 0;
        for (int i = 0; i < 35; i++) cnt += int'(h_tick[i]);
        chk("idle_tick_count", 32'(cnt), 32'd3);
        chk("idle_tick_9", 32'(h_tick[9]), 32'd1);

        // CPU write DT 0x2A, with a second request held during N+1/N+2.
        reset_dut();
        step(); step(); step();
        cv = 1; cop = 2'd1; cdat = 8'h2A;
        got = 0; n_acc = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (m_cacc) begin got = 1; n_acc = m_cyc - 1; end
        end
        chk("wr_dt_accepted", 32'(got), 32'd1);
        cop = 2'd1; cdat = 8'h11;
        for (int i = 0; i < 4; i++) step();
        cv = 0;
        step();
        chk("wr_dt_ld", 32'(h_ldd[n_acc+1]), 32'd1);
        chk("wr_dt_ldat", 32'(h_ldat[n_acc+1]), 32'h2A);
        chk("wr_dt_rv", 32'(h_crv[n_acc+2]), 32'd1);
        chk("wr_dt_rd", 32'(h_crd[n_acc+2]), 32'h2A);
        chk("wr_dt_rdy_n1", 32'(h_cr[n_acc+1]), 32'd0);
        chk("wr_dt_rdy_n2", 32'(h_cr[n_acc+2]), 32'd0);
        chk("wr_dt_rdy_n3", 32'(h_cr[n_acc+3]), 32'd1);

        // Sound load landing on cycle 19 defers that tick to 20.
        reset_dut();
        for (int i = 0; i < 18; i++) step();
        cv = 1; cop = 2'd2; cdat = 8'h09;
        step();
        cv = 0;
        for (int i = 19; i < 32; i++) step();
        chk("coll_ld_19", 32'(h_lds[19]), 32'd1);
        chk("coll_tick_19", 32'(h_tick[19]), 32'd0);
        chk("coll_tick_20", 32'(h_tick[20]), 32'd1);
        chk("coll_tick_29", 32'(h_tick[29]), 32'd1);
        chk("coll_tick_30", 32'(h_tick[30]), 32'd0);

        // Both ports requesting continuously from reset.
        reset_dut();
        cv = 1; cop = 2'd3; cdat = 8'h01; dv = 1; dop = 2'd3; ddat = 8'h02;
        for (int i = 0; i < 13; i++) step();
        cv = 0; dv = 0;
        for (int i = 0; i < 3; i++) step();
        chk("arb_c0", 32'(h_cr[0]), 32'd1);
`ifdef CHIP8_TMR_DBG_PORT_EN
        chk("arb_d3", 32'(h_dr[3]), 32'd1);
        chk("arb_c6", 32'(h_cr[6]), 32'd1);
        chk("arb_d9", 32'(h_dr[9]), 32'd1);
`else
        chk("arb_c3", 32'(h_cr[3]), 32'd1);
        chk("arb_c6", 32'(h_cr[6]), 32'd1);
        chk("arb_d9", 32'(h_dr[9]), 32'd0);
`endif

        // Read DT = 5, then buzzer follows sound 3 -> 0 with one cycle lag.
        reset_dut();
        dly = 8'h05; cv = 1; cop = 2'd0; cdat = 8'hEE;
        step();
        cv = 0;
        step();
        snd = 8'd3;
        for (int i = 2; i < 5; i++) step();
        snd = 8'd0;
        for (int i = 5; i < 8; i++) step();
        chk("rd_dt_rv", 32'(h_crv[2]), 32'd1);
        chk("rd_dt_rd", 32'(h_crd[2]), 32'h05);
        chk("buz_2", 32'(h_buz[2]), 32'd0);
        chk("buz_3", 32'(h_buz[3]), 32'd1);
        chk("buz_5", 32'(h_buz[5]), 32'd1);
        chk("buz_6", 32'(h_buz[6]), 32'd0);

        // Reset during the ISSUE cycle of a write aborts it.
        reset_dut();
        cv = 1; cop = 2'd1; cdat = 8'h77;
        step();
        chk("abort_acc", 32'(m_cacc), 32'd1);
        rst = 1; cv = 0;
        step();
        step();
        rst = 0; cv = 1;
        step();
        cv = 0;
        step();
        chk("abort_rdy", 32'(h_cr[0]), 32'd1);
        chk("abort_no_ld", 32'(h_ldd[0]), 32'd0);
        chk("abort_no_rv", 32'(h_crv[0]), 32'd0);

        // Randomised traffic with the occasional reset.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if (!cv || m_cacc) begin
                cv = ($urandom_range(0, 2) != 0); cop = 2'($urandom_range(0, 3)); cdat = 8'($urandom);
            end
            if (!dv || m_dacc) begin
                dv = ($urandom_range(0, 2) != 0); dop = 2'($urandom_range(0, 3)); ddat = 8'($urandom);
            end
            dly = 8'($urandom);
            snd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 499) == 0) reset_dut();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/chip8_timer_sched.md
# chip8_timer_sched

Scheduler and access arbiter for the CHIP-8 delay/sound timer datapath. It divides the system clock down to the 60 Hz decrement strobe, serialises timer loads and delay-timer reads from the CPU (FX07/FX15/FX18) and an optional debug host, and drives the buzzer enable. It sits between the CPU execute stage / debug bridge and the timer datapath, and is the only agent that drives the datapath's load inputs.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 60, decrement strobe rate in Hz; DIV = CLK_HZ/TICK_HZ (integer division), DIV >= 2 required.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_op  in  2  00 read DT, 01 write DT, 10 write ST, 11 reserved.
- cpu_req_data  in  8  write value; ignored for reads.
- cpu_req_ready  out  1  CPU request accepted this cycle.
- cpu_rsp_valid  out  1  one-cycle response strobe.
- cpu_rsp_data  out  8  read value (op 00) or written value (01/10).
- dbg_req_valid / dbg_req_op / dbg_req_data / dbg_req_ready / dbg_rsp_valid / dbg_rsp_data: debug port, same widths and meaning as the CPU port.
- tmr_tick  out  1  one-cycle decrement enable to the datapath.
- tmr_load_delay  out  1  one-cycle delay-timer load strobe.
- tmr_load_sound  out  1  one-cycle sound-timer load strobe.
- tmr_load_data  out  8  value for either load.
- tmr_delay_val  in  8  current delay-timer value.
- tmr_sound_val  in  8  current sound-timer value.
- buzzer  out  1  registered (tmr_sound_val != 0).

## Operation
- Prescaler: counter 0..DIV-1, increments every cycle, wraps to 0. A tick is due in the cycle the counter equals DIV-1.
- Tick/load collision: if a due tick coincides with a load strobe, tmr_tick stays 0 that cycle, tick_pending is set, and tmr_tick=1 in the next cycle. The prescaler keeps counting and no tick is lost. Loads never coincide back to back, so the deferral is always at most one cycle.
- FSM states:
  - IDLE: req_ready=1 for the port granted this cycle, 0 for the other.
  - ISSUE: drive load strobe with tmr_load_data, or sample tmr_delay_val into the response register.
  - RESP: rsp_valid=1 on the granting port for exactly one cycle, then return to IDLE.
- A request is accepted on valid&ready in IDLE, and the FSM moves to ISSUE.
- Arbitration: round-robin on the last_grant flag.
  - With one requester, that requester is granted.
  - With both requesting, the port not granted last is granted.
  - last_grant resets to dbg, so the CPU wins the first contention.
- op 11: accepted, no load strobe, response data 8'h00.
- Requesters must hold valid/op/data until accepted. Changing them before acceptance is undefined.
- Only one request is outstanding at a time. Both ready outputs stay 0 outside IDLE.

## Timing
- Reset values: all outputs 0, prescaler 0, tick_pending 0, FSM IDLE, response registers 8'h00, last_grant=dbg.
- Reset asserted mid-transaction aborts it: no rsp_valid, no load strobe after reset is released.
- Latency: accept in cycle N, load strobe or DT sample in N+1, rsp_valid in N+2. Earliest next accept is N+3.
- A read in ISSUE returns tmr_delay_val as seen in that cycle, including the effect of any tick in cycle N.
- First tick after reset release comes at cycle DIV-1, counting from the first clock edge with reset low as cycle 0. Later ticks follow every DIV cycles unless deferred.
- buzzer lags tmr_sound_val by one cycle.

## Configuration
- CHIP8_TMR_DBG_PORT_EN defined: debug port and round-robin arbiter are present as described.
- Macro undefined:
  - Debug ports remain in the port list but dbg_req_ready=0 and dbg_rsp_valid=0 always, with dbg_rsp_data=8'h00.
  - dbg_req_* inputs are ignored and the CPU is always granted.
  - last_grant logic is removed.

## Test plan
Bench uses CLK_HZ=600, TICK_HZ=60 (DIV=10).
- Reset release, idle 35 cycles -> tmr_tick pulses in cycles 9, 19, 29 only; all other outputs stay 0.
- CPU write DT 8'h2A accepted cycle N -> tmr_load_delay=1 and tmr_load_data=8'h2A in N+1; cpu_rsp_valid=1 with data 8'h2A in N+2; cpu_req_ready=0 in N+1 and N+2.
- CPU write ST timed so the load lands on cycle 19 -> tmr_tick=0 in 19, tmr_tick=1 in 20, next tick in 29.
- With CHIP8_TMR_DBG_PORT_EN, CPU and debug both hold valid from reset -> grants alternate cpu, dbg, cpu, dbg with accepts 3 cycles apart; without the macro -> only CPU accepted and dbg_req_ready stays 0.
- Datapath model holds DT=5, CPU read DT -> cpu_rsp_data=8'h05. Sound value 3 -> 0 -> buzzer goes 1 -> 0 one cycle after each change.
- Assert reset in the ISSUE cycle of a write -> no load strobe and no rsp_valid after release; FSM back in IDLE with ready=1.
